// File: rtl/CACHE.sv
// Command encoding shared by the memory pipeline and the cache responder.
package CACHE;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3
    } cache_cmd_t;
endpackage

// File: rtl/mcache_responder.sv
// Direct-mapped, write-through, no-write-allocate cache responder in front of a valid/ready memory port.
// Optional MCACHE_STATS_EN adds hit/miss/flush counters.
module mcache_responder #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  CACHE::cache_cmd_t   ca_req_cmd,
    input  logic [ADDR_W-1:0]   ca_req_addr,
    input  logic [63:0]         ca_req_data,
    output logic                ca_respcyc,
    output logic [63:0]         ca_resp_data,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [63:0]         mem_req_data,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [63:0]         mem_resp_data
`ifdef MCACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         flush_count
`endif
);
    import CACHE::*;

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 3 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MREQ   = 3'd2,
        S_MWAIT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t           state_r;
    cache_cmd_t       cmd_r;
    logic [ADDR_W-4:0] word_r;
    logic [63:0]      data_r;
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_mem_r  [LINES];
    logic [63:0]      data_mem_r [LINES];

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             hit_s;
    logic [63:0]      line_s;
    logic             line_we_s;
    logic             fill_s;
    logic [63:0]      line_wdata_s;
    logic             unused_addr_s;

    // Byte offset is not part of the word address.
    assign unused_addr_s = ^ca_req_addr[2:0];

    // Lookup on the captured address only.
    always_comb begin
        idx_s  = word_r[IDX_W-1:0];
        tag_s  = word_r[ADDR_W-4:IDX_W];
        hit_s  = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
        line_s = data_mem_r[idx_s];
    end

    // Line update: write hit patches data, read fill installs tag and data.
    always_comb begin
        line_we_s    = 1'b0;
        fill_s       = 1'b0;
        line_wdata_s = data_r;
        if (state_r == S_LOOKUP && cmd_r == WRITE && hit_s) begin
            line_we_s = 1'b1;
        end else if (state_r == S_MWAIT && mem_resp_valid) begin
            line_we_s    = 1'b1;
            fill_s       = 1'b1;
            line_wdata_s = mem_resp_data;
        end else begin
            line_we_s = 1'b0;
        end
    end

    // Tag/data storage; validity is tracked separately so these need no reset.
    always_ff @(posedge clk) begin
        if (line_we_s) begin
            data_mem_r[idx_s] <= line_wdata_s;
            if (fill_s) begin
                tag_mem_r[idx_s] <= tag_s;
            end
        end
    end

    // Command sequencer with registered response and memory request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            cmd_r         <= IDLE;
            word_r        <= '0;
            data_r        <= 64'd0;
            valid_r       <= '0;
            ca_respcyc    <= 1'b0;
            ca_resp_data  <= 64'd0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= 64'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    case (ca_req_cmd)
                        READ, WRITE, FLUSH: begin
                            cmd_r   <= ca_req_cmd;
                            word_r  <= ca_req_addr[ADDR_W-1:3];
                            data_r  <= ca_req_data;
                            state_r <= S_LOOKUP;
                        end
                        default: state_r <= S_IDLE;
                    endcase
                end
                S_LOOKUP: begin
                    case (cmd_r)
                        READ: begin
                            if (hit_s) begin
                                ca_respcyc   <= 1'b1;
                                ca_resp_data <= line_s;
                                state_r      <= S_RESP;
                            end else begin
                                mem_req_valid <= 1'b1;
                                mem_req_we    <= 1'b0;
                                mem_req_addr  <= {word_r, 3'b000};
                                state_r       <= S_MREQ;
                            end
                        end
                        WRITE: begin
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= {word_r, 3'b000};
                            mem_req_data  <= data_r;
                            state_r       <= S_MREQ;
                        end
                        FLUSH: begin
                            valid_r[idx_s] <= 1'b0;
                            ca_respcyc     <= 1'b1;
                            ca_resp_data   <= 64'd0;
                            state_r        <= S_RESP;
                        end
                        default: state_r <= S_IDLE;
                    endcase
                end
                S_MREQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_we) begin
                            ca_respcyc   <= 1'b1;
                            ca_resp_data <= 64'd0;
                            state_r      <= S_RESP;
                        end else begin
                            state_r <= S_MWAIT;
                        end
                    end
                end
                S_MWAIT: begin
                    if (mem_resp_valid) begin
                        valid_r[idx_s] <= 1'b1;
                        ca_respcyc     <= 1'b1;
                        ca_resp_data   <= mem_resp_data;
                        state_r        <= S_RESP;
                    end
                end
                S_RESP: begin
                    ca_respcyc   <= 1'b0;
                    ca_resp_data <= 64'd0;
                    state_r      <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

`ifdef MCACHE_STATS_EN
    // Event counters sampled at lookup; they wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count   <= 32'd0;
            miss_count  <= 32'd0;
            flush_count <= 32'd0;
        end else if (state_r == S_LOOKUP) begin
            case (cmd_r)
                READ, WRITE: begin
                    if (hit_s) begin
                        hit_count <= hit_count + 32'd1;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                    end
                end
                FLUSH:   flush_count <= flush_count + 32'd1;
                default: flush_count <= flush_count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mcache_responder.sv
// Directed bench for mcache_responder: misses, hits, write-through, flush, conflicts, reset abandon.
module tb_mcache_responder;
    import CACHE::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    cache_cmd_t  ca_req_cmd = IDLE;
    logic [63:0] ca_req_addr = 64'd0;
    logic [63:0] ca_req_data = 64'd0;
    logic        ca_respcyc;
    logic [63:0] ca_resp_data;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic        mem_req_ready = 1'b1;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = 64'd0;
`ifdef MCACHE_STATS_EN
    logic [31:0] hit_count, miss_count, flush_count;
`endif

    mcache_responder #(.LINES(64), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .ca_req_cmd(ca_req_cmd), .ca_req_addr(ca_req_addr), .ca_req_data(ca_req_data),
        .ca_respcyc(ca_respcyc), .ca_resp_data(ca_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
`ifdef MCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int rd_acc   = 0;
    int wr_acc   = 0;

    // Count accepted memory requests.
    always @(posedge clk) begin
        if (reset && mem_req_valid && mem_req_ready) begin
            if (mem_req_we) wr_acc <= wr_acc + 1;
            else            rd_acc <= rd_acc + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input cache_cmd_t c, input logic [63:0] a, input logic [63:0] d);
        ca_req_cmd  = c;
        ca_req_addr = a;
        ca_req_data = d;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ca_respcyc && n < 12);
    endtask

    task automatic close_resp(input string tag);
        ca_req_cmd = IDLE;
        @(negedge clk);
        chk({tag, "_pulse_end"}, {63'd0, ca_respcyc}, 64'd0);
        chk({tag, "_data_clr"}, ca_resp_data, 64'd0);
    endtask

    task automatic hit_read(input logic [63:0] a, input logic [63:0] exp, input string tag);
        int n;
        int r0;
        r0 = rd_acc;
        issue(READ, a, 64'd0);
        wait_resp(n);
        chk({tag, "_lat"}, 64'(n), 64'd2);
        chk({tag, "_data"}, ca_resp_data, exp);
        chk({tag, "_nomem"}, 64'(rd_acc), 64'(r0));
        close_resp(tag);
    endtask

    task automatic miss_read(input logic [63:0] a, input logic [63:0] rdata, input string tag);
        int n;
        int r0;
        logic [63:0] wa;
        r0 = rd_acc;
        wa = {a[63:3], 3'b000};
        issue(READ, a, 64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_valid && n < 12);
        chk({tag, "_mreq_lat"}, 64'(n), 64'd2);
        chk({tag, "_mreq_we"}, {63'd0, mem_req_we}, 64'd0);
        chk({tag, "_mreq_addr"}, mem_req_addr, wa);
        repeat (3) @(negedge clk);
        chk({tag, "_mreq_drop"}, {63'd0, mem_req_valid}, 64'd0);
        chk({tag, "_rd_count"}, 64'(rd_acc), 64'(r0 + 1));
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        chk({tag, "_resp"}, {63'd0, ca_respcyc}, 64'd1);
        chk({tag, "_data"}, ca_resp_data, rdata);
        close_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int w0;
        logic seen_resp;
        logic seen_req;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_respcyc", {63'd0, ca_respcyc}, 64'd0);
        chk("rst_resp_data", ca_resp_data, 64'd0);
        chk("rst_mreq_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_mreq_we", {63'd0, mem_req_we}, 64'd0);
        chk("rst_mreq_addr", mem_req_addr, 64'd0);
        chk("rst_mreq_data", mem_req_data, 64'd0);
`ifdef MCACHE_STATS_EN
        chk("rst_hits", {32'd0, hit_count}, 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Unknown command encoding is ignored
        issue(cache_cmd_t'(3'b111), 64'h1000, 64'd0);
        seen_resp = 1'b0;
        seen_req  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_resp = seen_resp | ca_respcyc;
            seen_req  = seen_req | mem_req_valid;
        end
        chk("unk_no_resp", {63'd0, seen_resp}, 64'd0);
        chk("unk_no_mreq", {63'd0, seen_req}, 64'd0);
        ca_req_cmd = IDLE;
        @(negedge clk);

        miss_read(64'h1000, 64'hDEADBEEF_CAFEF00D, "cold_rd");
        hit_read(64'h1000, 64'hDEADBEEF_CAFEF00D, "warm_rd");

        // Write-through with memory stalling for four cycles
        mem_req_ready = 1'b0;
        w0 = wr_acc;
        issue(WRITE, 64'h1000, 64'h1111);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_valid && n < 12);
        chk("wr_mreq_lat", 64'(n), 64'd2);
        chk("wr_mreq_we", {63'd0, mem_req_we}, 64'd1);
        chk("wr_mreq_addr", mem_req_addr, 64'h1000);
        chk("wr_mreq_data", mem_req_data, 64'h1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr_hold", {60'd0, mem_req_valid, mem_req_we, (mem_req_addr == 64'h1000),
                (mem_req_data == 64'h1111)}, 64'hF);
            chk("wr_no_resp", {63'd0, ca_respcyc}, 64'd0);
        end
        mem_req_ready = 1'b1;
        wait_resp(n);
        chk("wr_resp_lat", 64'(n), 64'd1);
        chk("wr_resp_data", ca_resp_data, 64'd0);
        chk("wr_count", 64'(wr_acc), 64'(w0 + 1));
        close_resp("wr");
        hit_read(64'h1000, 64'h1111, "rd_after_wr");

        // Flush then re-read must miss
        r0 = rd_acc;
        w0 = wr_acc;
        issue(FLUSH, 64'h1000, 64'd0);
        wait_resp(n);
        chk("flush_lat", 64'(n), 64'd2);
        chk("flush_data", ca_resp_data, 64'd0);
        chk("flush_nomem", 64'(rd_acc + wr_acc), 64'(r0 + w0));
        close_resp("flush");
        miss_read(64'h1000, 64'hA5A5A5A5_5A5A5A5A, "rd_after_flush");

        // Same index, different tag: evict and refill
        miss_read(64'h1200, 64'h12001200_12001200, "conflict_rd");
        miss_read(64'h1005, 64'h0BAD0BAD_0BAD0BAD, "refill_rd");

        // Back-to-back hits: next command presented right after the pulse
        issue(READ, 64'h1000, 64'd0);
        wait_resp(n);
        chk("b2b_first_lat", 64'(n), 64'd2);
        wait_resp(n);
        chk("b2b_spacing", 64'(n), 64'd3);
        chk("b2b_data", ca_resp_data, 64'h0BAD0BAD_0BAD0BAD);
        close_resp("b2b");

        // Reset while waiting for memory read data
        issue(READ, 64'h2000, 64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_valid && n < 12);
        @(negedge clk);
        reset = 1'b0;
        ca_req_cmd = IDLE;
        #1;
        chk("arst_mreq_valid", {63'd0, mem_req_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        seen_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_resp = seen_resp | ca_respcyc;
        end
        chk("arst_stray_resp", {63'd0, seen_resp}, 64'd0);
`ifdef MCACHE_STATS_EN
        chk("arst_hits", {32'd0, hit_count}, 64'd0);
        chk("arst_misses", {32'd0, miss_count}, 64'd0);
        chk("arst_flushes", {32'd0, flush_count}, 64'd0);
`endif
        miss_read(64'h1000, 64'h77777777_77777777, "post_rst_rd");
`ifdef MCACHE_STATS_EN
        chk("post_rst_misses", {32'd0, miss_count}, 64'd1);
        chk("post_rst_hits", {32'd0, hit_count}, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
